alu_src_rr_arbiter: RTL and testbench
=====================================

Name: alu_src_rr_arbiter

Overview:
- Round-robin arbiter sharing the 32-bit ALU operand path between four requesters.
- Drives the 2-bit select of the Mux4to1 operand-select tree in front of the ALU.
- Issues one-hot grants and holds each grant until the owner signals completion or drops its request.
- Sits between the requesting units (register read ports, immediate unit, etc.) and the operand mux/ALU.

Parameters:
- NUM_REQ, 4, number of requesters; fixed at 4 to match the 4:1 mux. Other values are unsupported.
- SEL_W, 2, width of the mux select; equals log2(NUM_REQ).
- TIMEOUT_CYCLES, 16, maximum BUSY cycles before a forced release. Used only with the optional feature. Legal range 2..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  4  request per requester; bit i = requester i.
- done  in  1  owner's transaction complete, sampled in BUSY only.
- gnt  out  4  one-hot grant, registered.
- sel  out  2  binary index of current/last owner, wired to Mux4to1 sel.
- busy  out  1  high while a grant is held.
- timeout  out  1  one-cycle pulse on a forced release.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low. Asserting rst_n=0 at any time, including mid-transaction, immediately forces:
  - state=IDLE
  - gnt=4'b0000, sel=2'b00, busy=0, timeout=0
  - round-robin pointer ptr=0
  - hold counter=0
- States: IDLE, BUSY (2-state FSM).
- IDLE:
  - If req==0, remain in IDLE; gnt=0.
  - Otherwise, on the clock edge, pick the winner = first i with req[i]=1, scanning ptr, ptr+1, ..., ptr+3 (mod 4).
  - Register gnt=onehot(winner), sel=winner, busy=1, ptr=winner+1 (mod 4, wraps 3->0), then enter BUSY.
  - Latency: req to gnt is 1 cycle.
- BUSY:
  - Release condition: done=1, or req[owner]=0, sampled at a clock edge.
  - On release: next state IDLE, gnt=0, busy=0. If done and req-drop occur together, this counts as a single release.
  - Requests from non-owners are ignored; no preemption.
- Dead cycle: every release costs one IDLE cycle, so back-to-back grants are separated by exactly one cycle with gnt=0.
- sel in IDLE: holds the last granted index so the mux output stays stable. After reset it is 0.
- done while IDLE: ignored.
- Output invariants: gnt is always one-hot or zero. busy == |gnt.
- Requester-side rule: a requester must keep req high until it sees gnt and finishes. Glitching req low during BUSY releases the grant.

Optional Feature:
- Macro: ALU_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on entry to BUSY and increments each BUSY cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 with no release condition, the next edge forces release to IDLE and timeout pulses high for exactly one cycle (registered, coincident with gnt going 0).
  - ptr advances normally, so the hung owner loses priority.
- Undefined:
  - No counter logic is synthesized.
  - timeout is tied to 0.
  - Grants are held indefinitely until done or req drop.

Decomposition:
- Shared package alu_arb_pkg holds:
  - NUM_REQ=4 and SEL_W=2 constants
  - state encoding: IDLE=1'b0, BUSY=1'b1
  - default TIMEOUT_CYCLES
- Sub-module rr_pick: purely combinational rotate-priority encoder.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: any, idx[1:0].
  - Also reusable by other shared-resource arbiters in the datapath.

Test Plan:
- Reset check: hold rst_n=0, drive req=4'b1111 -> gnt=0, sel=0, busy=0. Release reset, next edge -> gnt=4'b0001, sel=0.
- Rotation under full load: req=4'b1111 with done pulsed one cycle after each grant -> grant order 0,1,2,3,0 with one gnt=0 cycle between grants, and sel tracks the owner.
- Skip and wrap: ptr=3 (after granting 2), req=4'b0011 -> gnt=4'b0001 (wraps past 3), and ptr becomes 1.
- Req-drop release: owner 2 holds req for 5 cycles then drops it, done=0 -> gnt falls to 0 the edge after the drop. Simultaneous done+drop -> a single release.
- Async reset mid-BUSY: owner 1 granted, assert rst_n=0 between clock edges -> gnt=0 immediately (no clock). After release, req=4'b0010 is granted from ptr=0.
- With ALU_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, owner 0 never asserts done -> gnt cleared after 4 BUSY cycles with a one-cycle timeout pulse, then requester 1 is granted next if requesting. Without the macro, the grant persists 100+ cycles and timeout stays 0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU operand-source round-robin arbiter:
// requester count, mux select width, FSM state encoding, default hold
// timeout and a select-to-one-hot helper.
package alu_arb_pkg;

  localparam int NUM_REQ             = 4;
  localparam int SEL_W               = 2;
  localparam int DEF_TIMEOUT_CYCLES  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Convert a binary requester index into its one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/alu_src_rr_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority encoder. Scans req starting at
// ptr and wrapping modulo NUM_REQ; idx is the first requester found and
// any reports whether any requester is active. Reusable by other
// shared-resource arbiters in the datapath.
module rr_pick
  import alu_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic [NUM_REQ-1:0] rot_s;
  logic [SEL_W-1:0]   off_s;

  // Rotate req so that bit 0 is the requester at ptr, then priority-encode the offset.
  always_comb begin
    rot_s = 4'({req, req} >> ptr);
    off_s = 2'd0;
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: off_s = 2'd0;
    endcase
    any = |req;
    idx = ptr + off_s;
  end

endmodule

// File: rtl/alu_src_rr_arbiter.sv
// alu_src_rr_arbiter: round-robin arbiter for the shared 32-bit ALU operand
// path. Grants one of four requesters, drives the Mux4to1 select, and holds
// the grant until the owner signals done or drops its request. Every release
// passes through one IDLE cycle with gnt=0.
// Optional feature macro: ALU_ARB_TIMEOUT_EN (forced release of a hung owner
// after TIMEOUT_CYCLES busy cycles, with a one-cycle timeout pulse).
module alu_src_rr_arbiter
  import alu_arb_pkg::*;
`ifdef ALU_ARB_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
)
`endif
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               timeout
);

  state_t             state_r;
  state_t             next_state_s;
  logic [SEL_W-1:0]   ptr_r;
  logic [SEL_W-1:0]   ptr_s;
  logic [SEL_W-1:0]   sel_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic               busy_s;
  logic               pick_any_s;
  logic [SEL_W-1:0]   pick_idx_s;
  logic               owner_rel_s;

`ifdef ALU_ARB_TIMEOUT_EN
  logic [7:0] cnt_r;
  logic [7:0] cnt_s;
  logic       hit_s;
  logic       timeout_s;
`endif

  rr_pick u_pick (
    .req (req),
    .ptr (ptr_r),
    .any (pick_any_s),
    .idx (pick_idx_s)
  );

  // Owner releases when it signals done or drops its request; sel holds the owner in BUSY.
  always_comb begin
    owner_rel_s = done | ~req[sel];
  end

`ifdef ALU_ARB_TIMEOUT_EN
  // Hold counter has reached its limit for the current owner.
  always_comb begin
    hit_s = (cnt_r == 8'(TIMEOUT_CYCLES - 1));
  end
`endif

  // Next-state and next-output logic for the two-state grant FSM.
  always_comb begin
    next_state_s = state_r;
    gnt_s        = gnt;
    sel_s        = sel;
    ptr_s        = ptr_r;
    busy_s       = busy;
`ifdef ALU_ARB_TIMEOUT_EN
    cnt_s        = cnt_r;
    timeout_s    = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          next_state_s = BUSY;
          gnt_s        = sel_to_onehot(pick_idx_s);
          sel_s        = pick_idx_s;
          ptr_s        = pick_idx_s + 2'd1;
          busy_s       = 1'b1;
`ifdef ALU_ARB_TIMEOUT_EN
          cnt_s        = 8'd0;
`endif
        end else begin
          next_state_s = IDLE;
          gnt_s        = {NUM_REQ{1'b0}};
          busy_s       = 1'b0;
        end
      end
      BUSY: begin
        if (owner_rel_s) begin
          next_state_s = IDLE;
          gnt_s        = {NUM_REQ{1'b0}};
          busy_s       = 1'b0;
        end
`ifdef ALU_ARB_TIMEOUT_EN
        else if (hit_s) begin
          next_state_s = IDLE;
          gnt_s        = {NUM_REQ{1'b0}};
          busy_s       = 1'b0;
          timeout_s    = 1'b1;
        end else begin
          next_state_s = BUSY;
          cnt_s        = cnt_r + 8'd1;
        end
`else
        else begin
          next_state_s = BUSY;
        end
`endif
      end
      default: begin
        next_state_s = IDLE;
        gnt_s        = {NUM_REQ{1'b0}};
        busy_s       = 1'b0;
      end
    endcase
  end

  // FSM state, rotation pointer and registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= 2'd0;
      gnt     <= {NUM_REQ{1'b0}};
      sel     <= 2'd0;
      busy    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      ptr_r   <= ptr_s;
      gnt     <= gnt_s;
      sel     <= sel_s;
      busy    <= busy_s;
    end
  end

`ifdef ALU_ARB_TIMEOUT_EN
  // Hold counter and registered forced-release pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= 8'd0;
      timeout <= 1'b0;
    end else begin
      cnt_r   <= cnt_s;
      timeout <= timeout_s;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_alu_src_rr_arbiter.sv
// Directed self-checking bench for alu_src_rr_arbiter. Inputs change and
// outputs are sampled 1 time unit after each rising clock edge.
// Honours ALU_ARB_TIMEOUT_EN (runs with TIMEOUT_CYCLES=4 when defined).
module tb_alu_src_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

`ifdef ALU_ARB_TIMEOUT_EN
  alu_src_rr_arbiter #(.TIMEOUT_CYCLES(4)) dut (
`else
  alu_src_rr_arbiter dut (
`endif
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_st(input string tag, input logic [3:0] eg, input logic [1:0] es,
                           input logic et);
    check({tag, ".gnt"},     32'(gnt),     32'(eg));
    check({tag, ".sel"},     32'(sel),     32'(es));
    check({tag, ".busy"},    32'(busy),    32'(|eg));
    check({tag, ".timeout"}, 32'(timeout), 32'(et));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    done  = 1'b0;

    // Reset holds everything low even with all requests pending
    repeat (2) @(posedge clk);
    #1;
    expect_st("reset", 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    expect_st("first_gnt", 4'b0001, 2'd0, 1'b0);

    // Rotation under full load: 0 -> 1 -> 2 -> 3 -> 0 with one dead cycle each
    for (int k = 1; k <= 4; k++) begin
      done = 1'b1;
      tick();
      expect_st("rot_dead", 4'b0000, 2'((k - 1) % 4), 1'b0);
      done = 1'b0;
      tick();
      expect_st("rot_gnt", 4'(1 << (k % 4)), 2'(k % 4), 1'b0);
    end

    // Skip and wrap: grant 2 (ptr -> 3), then req=0011 wraps to 0 (ptr -> 1)
    done = 1'b1;
    req  = 4'b0100;
    tick();
    expect_st("wrap_rel", 4'b0000, 2'd0, 1'b0);
    done = 1'b0;
    tick();
    expect_st("wrap_g2", 4'b0100, 2'd2, 1'b0);
    req = 4'b0011;
    tick();
    expect_st("wrap_drop", 4'b0000, 2'd2, 1'b0);
    tick();
    expect_st("wrap_g0", 4'b0001, 2'd0, 1'b0);
    done = 1'b1;
    tick();
    expect_st("wrap_rel0", 4'b0000, 2'd0, 1'b0);
    done = 1'b0;
    tick();
    expect_st("wrap_ptr1", 4'b0010, 2'd1, 1'b0);

    // Req-drop release: owner 2 holds for 5 cycles, then drops
    req = 4'b0100;
    tick();
    expect_st("drop_rel1", 4'b0000, 2'd1, 1'b0);
    tick();
    expect_st("drop_g2", 4'b0100, 2'd2, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      expect_st("drop_hold", 4'b0100, 2'd2, 1'b0);
    end
    req = 4'b0000;
    tick();
    expect_st("drop_rel2", 4'b0000, 2'd2, 1'b0);

    // Simultaneous done + drop is a single release; done in IDLE is ignored
    req = 4'b1000;
    tick();
    expect_st("sim_g3", 4'b1000, 2'd3, 1'b0);
    req  = 4'b0000;
    done = 1'b1;
    tick();
    expect_st("sim_rel", 4'b0000, 2'd3, 1'b0);
    tick();
    expect_st("idle_done", 4'b0000, 2'd3, 1'b0);
    done = 1'b0;
    req  = 4'b0001;
    tick();
    expect_st("sim_g0", 4'b0001, 2'd0, 1'b0);

    // Async reset mid-BUSY with owner 1
    req = 4'b0010;
    tick();
    expect_st("ar_rel0", 4'b0000, 2'd0, 1'b0);
    tick();
    expect_st("ar_g1", 4'b0010, 2'd1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_st("ar_async", 4'b0000, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 4'b1010;
    tick();
    expect_st("ar_ptr0", 4'b0010, 2'd1, 1'b0);

    // Owner 0 never signals done while requester 1 waits
    req = 4'b0001;
    tick();
    expect_st("to_rel1", 4'b0000, 2'd1, 1'b0);
    tick();
    expect_st("to_g0", 4'b0001, 2'd0, 1'b0);
    req = 4'b0011;
`ifdef ALU_ARB_TIMEOUT_EN
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_st("to_hold", 4'b0001, 2'd0, 1'b0);
    end
    tick();
    expect_st("to_force", 4'b0000, 2'd0, 1'b1);
    tick();
    expect_st("to_next", 4'b0010, 2'd1, 1'b0);
`else
    for (int k = 0; k < 110; k++) begin
      tick();
      expect_st("hold_forever", 4'b0001, 2'd0, 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
